// File: rtl/ram_dump_arbiter_pkg.sv
// Shared state encoding, widths and byte-split helpers for the RAM dump arbiter.
package ram_dump_pkg;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT, SEND_HI, SEND_LO, NEXT, CSUM_HI, CSUM_LO, DONE
  } state_t;

  function automatic logic [BYTE_W-1:0] hi_byte(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[BYTE_W-1:0];
  endfunction
endpackage

// File: rtl/ram_dump_arbiter_if.sv
// Signal bundle around the arbiter: CPU RAM requests, the RAM port and the UART byte stream.
interface ram_dump_arbiter_if
  import ram_dump_pkg::*;
#(parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic              cpu_eoe;
  logic [WORD_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              dump_busy;
  logic              dump_done;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, cpu_eoe, ram_rdata, tx_ready,
    output cpu_rdata, ram_addr, ram_wdata, ram_we, ram_re, tx_data, tx_valid,
           dump_busy, dump_done
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, cpu_eoe, ram_rdata, tx_ready,
    input  cpu_rdata, ram_addr, ram_wdata, ram_we, ram_re, tx_data, tx_valid,
           dump_busy, dump_done
  );
endinterface

// File: rtl/ram_dump_arbiter_rd_lat_counter.sv
// Loadable down-counter; hit marks the cycle the RAM read data becomes valid.
module rd_lat_counter #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic hit
);
  logic [1:0] count;

  always_ff @(posedge clk) begin
    if (reset)             count <= '0;
    else if (load)         count <= 2'(RD_LAT - 1);
    else if (count != '0)  count <= count - 2'd1;
  end

  assign hit = (count == '0);
endmodule

// File: rtl/ram_dump_arbiter.sv
// Shares the data-RAM port between the CPU and an end-of-execution dump engine.
// Define RAM_DUMP_CHECKSUM_EN to append a 16-bit word sum (high byte first) after the data.
//   state   | meaning
//   IDLE    | CPU owns RAM, waiting for eoe
//   ISSUE   | one-cycle RAM read of current address
//   WAIT    | RAM read latency
//   SEND_HI | high byte offered to UART
//   SEND_LO | low byte offered to UART
//   NEXT    | advance address or finish
//   CSUM_*  | checksum bytes
//   DONE    | CPU owns RAM again, engine disarmed until reset
module ram_dump_arbiter
  import ram_dump_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DUMP_FIRST = 0,
  parameter int DUMP_LAST  = 63,
  parameter int RD_LAT     = 1
) (
  input logic             clk,
  input logic             reset,
  ram_dump_arbiter_if.slave bus
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] word;
  logic              rd_hit;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  rd_lat_counter #(.RD_LAT(RD_LAT)) u_rd_lat (
    .clk   (clk),
    .reset (reset),
    .load  (state == ISSUE),
    .hit   (rd_hit)
  );

  assign bus.cpu_rdata = bus.ram_rdata;

  // dump_busy tracks exactly the states in which the engine owns the port
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = bus.cpu_we;
    bus.ram_re    = bus.cpu_re;
    if (bus.dump_busy) begin
      bus.ram_addr = addr;
      bus.ram_we   = 1'b0;
      bus.ram_re   = (state == ISSUE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= ADDR_W'(DUMP_FIRST);
      word          <= '0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.dump_busy <= 1'b0;
      bus.dump_done <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.cpu_eoe) begin
          state         <= ISSUE;
          bus.dump_busy <= 1'b1;
        end
        ISSUE: state <= WAIT;
        WAIT: if (rd_hit) begin
          word         <= bus.ram_rdata;
          bus.tx_data  <= hi_byte(bus.ram_rdata);
          bus.tx_valid <= 1'b1;
          state        <= SEND_HI;
`ifdef RAM_DUMP_CHECKSUM_EN
          sum          <= sum + bus.ram_rdata;
`endif
        end
        SEND_HI: if (bus.tx_ready) begin
          bus.tx_data <= lo_byte(word);
          state       <= SEND_LO;
        end
        SEND_LO: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          state        <= NEXT;
        end
        NEXT: if (addr == ADDR_W'(DUMP_LAST)) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          bus.tx_valid  <= 1'b1;
          bus.tx_data   <= hi_byte(sum);
          state         <= CSUM_HI;
`else
          bus.dump_busy <= 1'b0;
          bus.dump_done <= 1'b1;
          state         <= DONE;
`endif
        end else begin
          addr  <= addr + 1'b1;
          state <= ISSUE;
        end
`ifdef RAM_DUMP_CHECKSUM_EN
        CSUM_HI: if (bus.tx_ready) begin
          bus.tx_data <= lo_byte(sum);
          state       <= CSUM_LO;
        end
        CSUM_LO: if (bus.tx_ready) begin
          bus.tx_valid  <= 1'b0;
          bus.dump_busy <= 1'b0;
          bus.dump_done <= 1'b1;
          state         <= DONE;
        end
`endif
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_dump_arbiter.sv
// Directed bench for ram_dump_arbiter: behavioural RAM, UART byte collector, word-stream model.
module tb_ram_dump_arbiter;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int ADDR_W = 6;
  localparam int NWORDS = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   we_leaks;

  ram_dump_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ram_dump_arbiter #(.ADDR_W(ADDR_W), .DUMP_FIRST(0), .DUMP_LAST(63), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [NWORDS];
  logic [15:0] pipe [4];
  logic [15:0] model_mem [NWORDS];
  logic [7:0]  rx_q [$];
  int          rx_t [$];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) pipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      rx_q.push_back(bus.tx_data);
      rx_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 6'(i);
      bus.cpu_wdata = (pat == 0) ? 16'(16'h0100 + i) : 16'h0001;
      model_mem[i]  = bus.cpu_wdata;
    end
    @(negedge clk);
    bus.cpu_we = 1'b0;
  endtask

  task automatic pulse_eoe();
    @(negedge clk);
    bus.cpu_eoe = 1'b1;
    @(negedge clk);
    bus.cpu_eoe = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    we_leaks = 0;
    while (!bus.dump_done && k < budget) begin
      @(negedge clk);
      if (bus.dump_busy && bus.ram_we) we_leaks++;
      k++;
    end
    if (!bus.dump_done) chk("timeout_done", 32'(bus.dump_done), 32'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rx_q.size() < n) chk("timeout_bytes", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic check_stream(input int base);
    logic [7:0]  exp_q [$];
    logic [15:0] sum = '0;
    int          got;
    for (int i = 0; i < NWORDS; i++) begin
      exp_q.push_back(model_mem[i][15:8]);
      exp_q.push_back(model_mem[i][7:0]);
      sum = sum + model_mem[i];
    end
`ifdef RAM_DUMP_CHECKSUM_EN
    exp_q.push_back(sum[15:8]);
    exp_q.push_back(sum[7:0]);
`endif
    got = rx_q.size() - base;
    chk("nbytes", 32'(got), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got; k++)
      chk($sformatf("byte%0d", k), 32'(rx_q[base+k]), 32'(exp_q[k]));
  endtask

  initial begin
    int base;
    int k;
    reset         = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_eoe   = 1'b0;
    bus.tx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(bus.dump_busy), 32'd0);
    chk("rst_done", 32'(bus.dump_done), 32'd0);
    reset = 1'b0;

    // CPU pass-through in IDLE
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_addr = 6'd5; bus.cpu_wdata = 16'hBEEF;
    #1;
    chk("pt_we", 32'(bus.ram_we), 32'd1);
    chk("pt_addr", 32'(bus.ram_addr), 32'd5);
    chk("pt_wdata", 32'(bus.ram_wdata), 32'hBEEF);
    chk("pt_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("pt_busy", 32'(bus.dump_busy), 32'd0);
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    #1;
    chk("pt_re", 32'(bus.ram_re), 32'd1);
    @(negedge clk);
    bus.cpu_re = 1'b0;
    repeat (RD_LAT-1) @(negedge clk);
    chk("pt_rdata", 32'(bus.cpu_rdata), 32'hBEEF);

    // Full dump with 1-cycle eoe pulse
    fill(0);
    base = rx_q.size();
    pulse_eoe();
    wait_done(3000);
    check_stream(base);
    if (rx_q.size() - base >= 3) begin
      chk("lat_lo", 32'(rx_t[base+1] - rx_t[base]), 32'd1);
      chk("lat_word", 32'(rx_t[base+2] - rx_t[base]), 32'(RD_LAT + 4));
    end
    chk("done_busy", 32'(bus.dump_busy), 32'd0);
    chk("done_flag", 32'(bus.dump_done), 32'd1);
    @(negedge clk);
    bus.cpu_re = 1'b1; bus.cpu_addr = 6'd9;
    #1;
    chk("done_pt_re", 32'(bus.ram_re), 32'd1);
    chk("done_pt_addr", 32'(bus.ram_addr), 32'd9);
    @(negedge clk);
    bus.cpu_re = 1'b0;

    // Back-pressure on SEND_HI of word 3
    do_reset();
    base = rx_q.size();
    pulse_eoe();
    wait_bytes(base + 6, 200);
    k = 0;
    while (!bus.tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", 32'(bus.tx_data), 32'h01);
      chk("bp_valid", 32'(bus.tx_valid), 32'd1);
      chk("bp_re", 32'(bus.ram_re), 32'd0);
    end
    chk("bp_count", 32'(rx_q.size() - base), 32'd6);
    bus.tx_ready = 1'b1;
    wait_done(3000);
    check_stream(base);

    // CPU write attempts during dump, then eoe re-pulse in DONE
    do_reset();
    base = rx_q.size();
    pulse_eoe();
    bus.cpu_we = 1'b1; bus.cpu_addr = 6'd7; bus.cpu_wdata = 16'hDEAD;
    wait_done(3000);
    chk("we_leak", 32'(we_leaks), 32'd0);
    @(negedge clk);
    bus.cpu_we = 1'b0;
    check_stream(base);
    base = rx_q.size();
    pulse_eoe();
    repeat (40) @(negedge clk);
    chk("redump_bytes", 32'(rx_q.size() - base), 32'd0);
    chk("redump_busy", 32'(bus.dump_busy), 32'd0);
    chk("redump_done", 32'(bus.dump_done), 32'd1);

    // Reset mid-dump after 9 bytes, then a fresh dump restarts at DUMP_FIRST
    do_reset();
    base = rx_q.size();
    pulse_eoe();
    wait_bytes(base + 9, 200);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(bus.tx_valid), 32'd0);
    chk("abort_busy", 32'(bus.dump_busy), 32'd0);
    chk("abort_done", 32'(bus.dump_done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_bytes", 32'(rx_q.size() - base), 32'd9);
    base = rx_q.size();
    pulse_eoe();
    wait_bytes(base + 2, 200);
    if (rx_q.size() - base >= 2) begin
      chk("restart_b0", 32'(rx_q[base]), 32'h01);
      chk("restart_b1", 32'(rx_q[base+1]), 32'h00);
    end
    wait_done(3000);

`ifdef RAM_DUMP_CHECKSUM_EN
    // All-ones RAM: checksum is 64 = 16'h0040
    do_reset();
    fill(1);
    base = rx_q.size();
    pulse_eoe();
    wait_done(3000);
    check_stream(base);
    if (rx_q.size() - base == 130) begin
      chk("csum_hi", 32'(rx_q[base+128]), 32'h00);
      chk("csum_lo", 32'(rx_q[base+129]), 32'h40);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
